// File: rtl/problema1qsys_botoes_poller.sv
// Avalon-MM master that polls a button PIO, debounces the active-low samples,
// counts press events and mirrors the debounced state onto an LED PIO.
module problema1qsys_botoes_poller #(
  parameter int WIDTH            = 4,
  parameter int POLL_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       btn_address,
  output logic             btn_read,
  input  logic [31:0]      btn_readdata,
  output logic [1:0]       led_address,
  output logic             led_write,
  output logic [31:0]      led_writedata,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] press_pulse,
  output logic [7:0]       press_count
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_DIV - 1);
  localparam logic [3:0]    DS        = 4'(DEBOUNCE_SAMPLES);

  typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, WRITE} state_t;

  state_t           state;
  logic [CW-1:0]    poll_cnt;
  logic [WIDTH-1:0] sample, last_sample;
  logic [3:0]       stable_cnt;
  logic             btn_read_q, led_write_q;

  logic [3:0]       stable_nxt;
  logic             accept;
  logic [WIDTH-1:0] pulse_nxt;
  logic [31:0]      wd_nxt;
  logic [7:0]       pulse_pop;

  // Only the low WIDTH bits of readdata carry buttons.
  logic unused_readdata;
  assign unused_readdata = ^btn_readdata;

  assign btn_address = 2'd0;
  assign led_address = 2'd0;
  // Strobes are gated by reset so an in-flight access is dropped immediately.
  assign btn_read    = btn_read_q & ~reset;
  assign led_write   = led_write_q & ~reset;

  always_comb begin
    stable_nxt = 4'd1;
    if (sample == last_sample)
      stable_nxt = (stable_cnt >= DS) ? DS : stable_cnt + 4'd1;
    accept    = (stable_nxt == DS) && (~sample != pressed);
    pulse_nxt = ~sample & ~pressed;
    wd_nxt    = '0;
    wd_nxt[WIDTH-1:0] = ~sample;
    pulse_pop = '0;
    for (int i = 0; i < WIDTH; i++)
      pulse_pop = pulse_pop + 8'(pulse_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      poll_cnt      <= '0;
      sample        <= '1;
      last_sample   <= '1;
      stable_cnt    <= '0;
      btn_read_q    <= 1'b0;
      led_write_q   <= 1'b0;
      led_writedata <= '0;
      pressed       <= '0;
      press_pulse   <= '0;
      press_count   <= '0;
    end else begin
      btn_read_q  <= 1'b0;
      led_write_q <= 1'b0;
      press_pulse <= '0;
      poll_cnt    <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
      case (state)
        IDLE: if (poll_cnt == POLL_LAST) begin
          state      <= READ;
          btn_read_q <= 1'b1;
        end
        READ: state <= WAIT;
        WAIT: begin
          sample <= btn_readdata[WIDTH-1:0];
          state  <= EVAL;
        end
        EVAL: begin
          stable_cnt  <= stable_nxt;
          last_sample <= sample;
          if (accept) begin
            pressed       <= ~sample;
            press_pulse   <= pulse_nxt;
            press_count   <= press_count + pulse_pop;
            led_writedata <= wd_nxt;
            led_write_q   <= 1'b1;
            state         <= WRITE;
          end else begin
            state <= IDLE;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_problema1qsys_botoes_poller.sv
// Scoreboarded bench for the button poller: expected LED writes/pulses are queued
// when buttons change and checked by a monitor when the DUT issues them.
module tb_problema1qsys_botoes_poller;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  btn_address, led_address;
  logic        btn_read, led_write;
  logic [31:0] btn_readdata, led_writedata;
  logic [3:0]  pressed, press_pulse;
  logic [7:0]  press_count;

  problema1qsys_botoes_poller #(.WIDTH(4), .POLL_DIV(8), .DEBOUNCE_SAMPLES(3)) dut (
    .clk(clk), .reset(reset),
    .btn_address(btn_address), .btn_read(btn_read), .btn_readdata(btn_readdata),
    .led_address(led_address), .led_write(led_write), .led_writedata(led_writedata),
    .pressed(pressed), .press_pulse(press_pulse), .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] wd;
    logic [3:0]  pulse;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] btns = 4'hF;
  logic [3:0] model_pressed = '0;
  logic [7:0] model_cnt = '0;

  // Slave model: readdata registered every clock, junk in the unused upper bits.
  always @(posedge clk) btn_readdata <= {28'($urandom), btns};

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (btn_read && led_write) begin
        errors++; $display("FAIL strobe_overlap btn_read=%b led_write=%b", btn_read, led_write);
      end
      checks++;
      if (btn_address !== 2'd0 || led_address !== 2'd0) begin
        errors++; $display("FAIL address got %0d/%0d want 0/0", btn_address, led_address);
      end
      if (led_write || press_pulse != 4'h0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event led_write=%b wd=%h pulse=%b", led_write, led_writedata, press_pulse);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (led_write !== 1'b1 || led_writedata !== e.wd || press_pulse !== e.pulse ||
              press_count !== e.cnt || pressed !== e.wd[3:0]) begin
            errors++;
            $display("FAIL sb_event got w=%b wd=%h pulse=%b cnt=%0d pressed=%b want w=1 wd=%h pulse=%b cnt=%0d",
                     led_write, led_writedata, press_pulse, press_count, pressed, e.wd, e.pulse, e.cnt);
          end
        end
      end
    end
  end

  task automatic expect_change(input logic [3:0] nb);
    exp_t e;
    logic [3:0] np;
    np      = ~nb;
    e.pulse = np & ~model_pressed;
    model_cnt     = model_cnt + 8'($countones(e.pulse));
    model_pressed = np;
    e.wd  = {28'h0, np};
    e.cnt = model_cnt;
    q.push_back(e);
    btns = nb;
  endtask

  task automatic wait_read();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!btn_read && n < 20);
    if (!btn_read) begin
      checks++; errors++; $display("FAIL wait_read timeout after %0d clk", n);
    end
  endtask

  task automatic wait_polls(input int n);
    repeat (n * 8) @(negedge clk);
  endtask

  task automatic release_and_time(input string name);
    int n;
    n = 0;
    reset = 1'b0;
    do begin @(negedge clk); n++; end while (!btn_read && n < 20);
    checks++;
    if (n != 8 || !btn_read) begin
      errors++; $display("FAIL %s first_read got %0d clk want 8", name, n);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; btns = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if ({btn_read, led_write, led_writedata, pressed, press_pulse, press_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b wr=%b wd=%h pr=%b pu=%b cnt=%0d want all 0",
               btn_read, led_write, led_writedata, pressed, press_pulse, press_count);
    end
    release_and_time("reset");
    n = 0;
    do begin @(negedge clk); n++; end while (!btn_read && n < 20);
    checks++;
    if (n != 8) begin errors++; $display("FAIL poll_period got %0d want 8", n); end
    wait_polls(10);
    checks++;
    if (pressed !== 4'h0 || press_count !== 8'd0 || q.size() != 0) begin
      errors++; $display("FAIL reset_idle got pressed=%b cnt=%0d want 0 0", pressed, press_count);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 6; i++) begin
      wait_read();
      btns = btns ^ 4'h1;
    end
    btns = 4'hF;
    wait_polls(5);
    checks++;
    if (pressed !== 4'h0 || press_count !== 8'd0) begin
      errors++; $display("FAIL bounce got pressed=%b cnt=%0d want 0 0", pressed, press_count);
    end
  endtask

  task automatic test_press();
    expect_change(4'hE);
    wait_polls(5);
    checks++;
    if (pressed !== 4'b0001 || press_count !== 8'd1 || q.size() != 0) begin
      errors++; $display("FAIL press got pressed=%b cnt=%0d pending=%0d want 0001 1 0",
                         pressed, press_count, q.size());
    end
  endtask

  task automatic test_second_and_release();
    expect_change(4'hC);
    wait_polls(5);
    checks++;
    if (pressed !== 4'b0011 || press_count !== 8'd2 || led_writedata !== 32'h3 || q.size() != 0) begin
      errors++; $display("FAIL second got pressed=%b cnt=%0d wd=%h want 0011 2 3",
                         pressed, press_count, led_writedata);
    end
    expect_change(4'hF);
    wait_polls(5);
    checks++;
    if (pressed !== 4'h0 || press_count !== 8'd2 || led_writedata !== 32'h0 || q.size() != 0) begin
      errors++; $display("FAIL release got pressed=%b cnt=%0d wd=%h want 0 2 0",
                         pressed, press_count, led_writedata);
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1; btns = 4'hF;
    repeat (2) @(negedge clk);
    model_pressed = '0; model_cnt = '0;
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      expect_change(4'h0);
      wait_polls(5);
      expect_change(4'hF);
      wait_polls(5);
    end
    checks++;
    if (press_count !== 8'd0 || pressed !== 4'h0 || q.size() != 0) begin
      errors++; $display("FAIL wrap got cnt=%0d pressed=%b pending=%0d want 0 0 0",
                         press_count, pressed, q.size());
    end
  endtask

  task automatic test_reset_midop();
    int n;
    expect_change(4'hE);
    wait_polls(5);
    // reset during WAIT
    wait_read();
    @(negedge clk);
    #2 reset = 1'b1;
    btns = 4'hF;
    @(posedge clk); #1;
    checks++;
    if ({btn_read, led_write, led_writedata, pressed, press_pulse, press_count} !== '0) begin
      errors++; $display("FAIL wait_reset got rd=%b wr=%b wd=%h pr=%b cnt=%0d want all 0",
                         btn_read, led_write, led_writedata, pressed, press_count);
    end
    model_pressed = '0; model_cnt = '0;
    @(negedge clk);
    release_and_time("wait_reset");
    // reset during WRITE
    expect_change(4'hE);
    n = 0;
    while (!led_write && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (!led_write) begin
      errors++; $display("FAIL write_wait timeout after %0d clk", n);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (led_write !== 1'b0) begin
      errors++; $display("FAIL write_drop got led_write=%b want 0", led_write);
    end
    btns = 4'hF;
    @(posedge clk); #1;
    checks++;
    if ({led_writedata, pressed, press_pulse, press_count} !== '0) begin
      errors++; $display("FAIL write_reset got wd=%h pr=%b pu=%b cnt=%0d want all 0",
                         led_writedata, pressed, press_pulse, press_count);
    end
    model_pressed = '0; model_cnt = '0;
    @(negedge clk);
    release_and_time("write_reset");
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL pending got %0d want 0", q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_bounce();
    test_press();
    test_second_and_release();
    test_back_to_back();
    test_reset_midop();
    wait_polls(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
